// File: rtl/mips16_multi_cycle.sv
// Multi-cycle 16-bit MIPS-style core: IDLE/FETCH/DECODE/EXEC/MEM/WB sequencer sharing one ALU
// and one data-memory port, with a loadable instruction memory and run/halt control.
module mips16_multi_cycle #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned DMEM_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [15:0]                   prog_data,
  output logic                          halted,
  output logic                          retire,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc_out,
  output logic [DATA_W-1:0]             alu_out
);

  localparam int unsigned PW = $clog2(IMEM_DEPTH);
  localparam int unsigned DW = $clog2(DMEM_DEPTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_SW   = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_t;

  state_t state, state_next;
  logic   retire_next;

  logic [15:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, s_q, mdr, alu_res;
  logic [DATA_W-1:0] rf   [16];
  logic [15:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic [3:0]        op, ra, rb, rc;
  logic [DATA_W-1:0] imm;
  logic [15:0]       br_off;
  logic [PW-1:0]     pc_plus1, br_target, j_target;
  logic [DW-1:0]     maddr;
  logic              is_reg_alu, is_alu, is_short, beq_taken;

  assign op         = ir[15:12];
  assign ra         = ir[11:8];
  assign rb         = ir[7:4];
  assign rc         = ir[3:0];
  assign imm        = {{(DATA_W-4){ir[3]}}, ir[3:0]};
  assign br_off     = {{12{ir[3]}}, ir[3:0]};
  assign is_reg_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) ||
                      (op == OP_OR)  || (op == OP_AND);
  assign is_alu     = is_reg_alu || (op == OP_ADDI);
  // J, BEQ, NOP and HALT all finish in EXEC
  assign is_short   = !(is_alu || (op == OP_LW) || (op == OP_SW));
  assign beq_taken  = (s_q == a_q);
  assign pc_plus1   = pc_out + PW'(1);
  assign br_target  = pc_plus1 + PW'(br_off);
  assign j_target   = PW'(ir[11:0]);
  assign maddr      = DW'(alu_out);

  function automatic logic [DATA_W-1:0] rd(input logic [3:0] idx);
    return (idx == 4'd0) ? '0 : rf[idx];
  endfunction

  always_comb begin
    alu_res = a_q + b_q;
    case (op)
      OP_SUB:  alu_res = a_q - b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_AND:  alu_res = a_q & b_q;
      default: ;
    endcase
  end

  // retire is registered, so it is decided on entry to an instruction's final state
  always_comb begin
    state_next  = state;
    retire_next = 1'b0;
    case (state)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        state_next  = S_EXEC;
        retire_next = is_short;
      end
      S_EXEC: begin
        if (op == OP_HALT) begin
          state_next = S_IDLE;
        end else if (is_short) begin
          state_next = S_FETCH;
        end else if ((op == OP_LW) || (op == OP_SW)) begin
          state_next  = S_MEM;
          retire_next = (op == OP_SW);
        end else begin
          state_next  = S_WB;
          retire_next = 1'b1;
        end
      end
      S_MEM: begin
        if (op == OP_LW) begin
          state_next  = S_WB;
          retire_next = 1'b1;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_WB:     state_next = S_FETCH;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      halted <= 1'b1;
      retire <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= (state_next == S_IDLE);
      retire <= retire_next;
    end
  end

  // Architectural state: PC, result register and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out  <= '0;
      alu_out <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= DATA_W'(i);
    end else begin
      case (state)
        S_EXEC: begin
          if (!is_short) alu_out <= alu_res;
          case (op)
            OP_J:    pc_out <= j_target;
            OP_BEQ:  pc_out <= beq_taken ? br_target : pc_plus1;
            OP_HALT: pc_out <= pc_out;
            default: if (is_short) pc_out <= pc_plus1;
          endcase
        end
        S_MEM: if (op == OP_SW) pc_out <= pc_plus1;
        S_WB: begin
          pc_out <= pc_plus1;
          if (ra != 4'd0) rf[ra] <= (op == OP_LW) ? mdr : alu_out;
        end
        default: ;
      endcase
    end
  end

  // Non-reset pipeline latches and memories
  always_ff @(posedge clk) begin
    if (!rst && (state == S_IDLE) && prog_we) imem[prog_addr] <= prog_data;
    if (state == S_FETCH) ir <= imem[pc_out];
    if (state == S_DECODE) begin
      a_q <= rd(rb);
      b_q <= is_reg_alu ? rd(rc) : imm;
      s_q <= rd(ra);
    end
    if ((state == S_MEM) && (op == OP_LW)) mdr <= dmem[maddr];
    if (!rst && (state == S_MEM) && (op == OP_SW)) dmem[maddr] <= s_q;
  end

endmodule
